// File: rtl/line_clock_gen_pkg.sv
// Shared defaults, enable-source encoding and counter sizing helpers for the
// line-clock / CPU-pacing generator and the board tops that use it.
package line_clock_gen_pkg;

   localparam int unsigned DEF_CLK_HZ  = 100_000_000;
   localparam int unsigned DEF_EVT_HZ0 = 50;
   localparam int unsigned DEF_EVT_HZ1 = 60;

   typedef enum logic [1:0] {
      EN_KEEP,
      EN_CLEAR,
      EN_WRITE,
      EN_TOGGLE
   } en_src_e;

   // Bits needed for a counter that runs 0..n-1, never less than one.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic en_src_e en_src(input logic dclo, input logic we, input logic tog);
      en_src_e src;
      if (dclo)
         src = EN_CLEAR;
      else if (we)
         src = EN_WRITE;
      else if (tog)
         src = EN_TOGGLE;
      else
         src = EN_KEEP;
      return src;
   endfunction

endpackage

// File: rtl/line_clock_gen_debounce_toggle.sv
// Front-panel button debouncer: synchroniser, sample prescaler, shift register
// and armed flag; emits a single-cycle toggle request per stable press.
module debounce_toggle
   import line_clock_gen_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = 100_000,
   parameter int unsigned DEB_LEN    = 4
) (
   input  logic clk_p,
   input  logic rst_n,
   input  logic dclo,
   input  logic button,
   output logic toggle_req
);

   localparam int unsigned   SW     = cnt_w(SAMPLE_DIV);
   localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_DIV - 1);

   logic [1:0]         sync;
   logic [SW-1:0]      scnt;
   logic [DEB_LEN-1:0] shreg;
   logic               armed;
   logic               press;
   logic               release_s;

   assign press     = &shreg;
   assign release_s = ~|shreg;

   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         sync       <= '0;
         scnt       <= '0;
         shreg      <= '0;
         armed      <= 1'b1;
         toggle_req <= 1'b0;
      end else begin
         sync <= {sync[0], button};
         if (scnt == S_LAST) begin
            scnt  <= '0;
            shreg <= {shreg[DEB_LEN-2:0], sync[1]};
         end else begin
            scnt <= scnt + SW'(1);
         end
         // dclo re-arms but never lets a press through in the same cycle
         if (dclo) begin
            armed      <= 1'b1;
            toggle_req <= 1'b0;
         end else begin
            toggle_req <= press & armed;
            if (press & armed)
               armed <= 1'b0;
            else if (release_s)
               armed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/line_clock_gen.sv
// Line-clock / CPU-pacing generator: CPU clock-enable divider, 50/60 Hz event
// prescaler, timer enable arbitration and optional latched event with overrun.
module line_clock_gen
   import line_clock_gen_pkg::*;
#(
   parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
   parameter int unsigned EVT_HZ0   = DEF_EVT_HZ0,
   parameter int unsigned EVT_HZ1   = DEF_EVT_HZ1,
   parameter int unsigned CEN_DIV   = 22,
   parameter int unsigned DEB_HZ    = 1000,
   parameter int unsigned DEB_LEN   = 4,
   parameter bit          EVT_LATCH = 1'b0,
   parameter bit          EN_RESET  = 1'b0
) (
   input  logic clk_p,
   input  logic rst_n,
   input  logic dclo,
   input  logic freq_sel,
   input  logic button,
   input  logic en_we,
   input  logic en_d,
   input  logic evnt_ack,
   output logic cpu_clk_ena,
   output logic tick,
   output logic evnt,
   output logic evnt_ovr,
   output logic timer_status
);

   localparam int unsigned P0   = CLK_HZ / EVT_HZ0;
   localparam int unsigned P1   = CLK_HZ / EVT_HZ1;
   localparam int unsigned PMAX = (P0 > P1) ? P0 : P1;
   localparam int unsigned PW   = cnt_w(PMAX);
   localparam logic [PW-1:0] P0_LAST = PW'(P0 - 1);
   localparam logic [PW-1:0] P1_LAST = PW'(P1 - 1);

   logic          toggle_req;
   logic          psel;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] p_last;

   debounce_toggle #(
      .SAMPLE_DIV (CLK_HZ / DEB_HZ),
      .DEB_LEN    (DEB_LEN)
   ) u_deb (
      .clk_p      (clk_p),
      .rst_n      (rst_n),
      .dclo       (dclo),
      .button     (button),
      .toggle_req (toggle_req)
   );

   generate
      if (CEN_DIV <= 1) begin : g_cen_const
         always_ff @(posedge clk_p or negedge rst_n) begin
            if (!rst_n)
               cpu_clk_ena <= 1'b0;
            else
               cpu_clk_ena <= 1'b1;
         end
      end else begin : g_cen_div
         localparam int unsigned   CW     = cnt_w(CEN_DIV);
         localparam logic [CW-1:0] C_LAST = CW'(CEN_DIV - 1);
         logic [CW-1:0] ccnt;
         always_ff @(posedge clk_p or negedge rst_n) begin
            if (!rst_n) begin
               ccnt        <= '0;
               cpu_clk_ena <= 1'b0;
            end else if (ccnt == C_LAST) begin
               ccnt        <= '0;
               cpu_clk_ena <= 1'b1;
            end else begin
               ccnt        <= ccnt + CW'(1);
               cpu_clk_ena <= 1'b0;
            end
         end
      end
   endgenerate

   // Rate select is latched only at wrap so a period is never cut short.
   assign p_last = psel ? P1_LAST : P0_LAST;

   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
         psel <= 1'b0;
         tick <= 1'b0;
      end else if (pcnt == p_last) begin
         pcnt <= '0;
         psel <= freq_sel;
         tick <= 1'b1;
      end else begin
         pcnt <= pcnt + PW'(1);
         tick <= 1'b0;
      end
   end

   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         timer_status <= EN_RESET;
         evnt         <= 1'b0;
         evnt_ovr     <= 1'b0;
      end else begin
         case (en_src(dclo, en_we, toggle_req))
            EN_CLEAR:  timer_status <= 1'b0;
            EN_WRITE:  timer_status <= en_d;
            EN_TOGGLE: timer_status <= ~timer_status;
            default:   timer_status <= timer_status;
         endcase

         if (!timer_status || dclo) begin
            evnt     <= 1'b0;
            evnt_ovr <= 1'b0;
         end else if (!EVT_LATCH) begin
            evnt     <= tick;
            evnt_ovr <= 1'b0;
         end else if (evnt_ack) begin
            evnt     <= tick;
            evnt_ovr <= 1'b0;
         end else if (tick) begin
            evnt     <= 1'b1;
            evnt_ovr <= evnt_ovr | evnt;
         end
      end
   end

endmodule

// File: tb/tb_line_clock_gen.sv
// Bench for line_clock_gen: pulse and latched event variants driven in
// parallel, compared every cycle against a cycle-count based reference model.
module tb_line_clock_gen;

   localparam int unsigned CLK_HZ  = 1000;
   localparam int unsigned EVT_HZ0 = 50;
   localparam int unsigned EVT_HZ1 = 100;
   localparam int unsigned CEN_DIV = 22;
   localparam int unsigned DEB_HZ  = 250;
   localparam int unsigned DEB_LEN = 2;
   localparam int unsigned P0      = CLK_HZ / EVT_HZ0;
   localparam int unsigned P1      = CLK_HZ / EVT_HZ1;
   localparam int unsigned DEB_DIV = CLK_HZ / DEB_HZ;

   logic clk = 1'b0;
   logic rst_n, dclo, freq_sel, button, en_we, en_d, evnt_ack;
   logic cen0, tick0, evnt0, ovr0, ts0;
   logic cen1, tick1, evnt1, ovr1, ts1;

   int errors = 0;
   int checks = 0;

   // reference model state
   int  m_cyc, m_next;
   bit  m_cen, m_tick, m_ev0, m_ev1, m_ovr1, m_ts, m_armed, m_tog;
   bit  samp[$];
   bit  bhist[$];

   always #5 clk = ~clk;

   line_clock_gen #(
      .CLK_HZ(CLK_HZ), .EVT_HZ0(EVT_HZ0), .EVT_HZ1(EVT_HZ1), .CEN_DIV(CEN_DIV),
      .DEB_HZ(DEB_HZ), .DEB_LEN(DEB_LEN), .EVT_LATCH(1'b0), .EN_RESET(1'b0)
   ) dut0 (
      .clk_p(clk), .rst_n(rst_n), .dclo(dclo), .freq_sel(freq_sel), .button(button),
      .en_we(en_we), .en_d(en_d), .evnt_ack(evnt_ack), .cpu_clk_ena(cen0), .tick(tick0),
      .evnt(evnt0), .evnt_ovr(ovr0), .timer_status(ts0)
   );

   line_clock_gen #(
      .CLK_HZ(CLK_HZ), .EVT_HZ0(EVT_HZ0), .EVT_HZ1(EVT_HZ1), .CEN_DIV(CEN_DIV),
      .DEB_HZ(DEB_HZ), .DEB_LEN(DEB_LEN), .EVT_LATCH(1'b1), .EN_RESET(1'b0)
   ) dut1 (
      .clk_p(clk), .rst_n(rst_n), .dclo(dclo), .freq_sel(freq_sel), .button(button),
      .en_we(en_we), .en_d(en_d), .evnt_ack(evnt_ack), .cpu_clk_ena(cen1), .tick(tick1),
      .evnt(evnt1), .evnt_ovr(ovr1), .timer_status(ts1)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d: got %b expected %b", tag, m_cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = 0; m_next = P0;
      m_cen = 0; m_tick = 0; m_ev0 = 0; m_ev1 = 0; m_ovr1 = 0;
      m_ts = 0; m_armed = 1; m_tog = 0;
      samp.delete(); bhist.delete();
      for (int i = 0; i < DEB_LEN; i++) samp.push_back(1'b0);
      bhist.push_back(1'b0); bhist.push_back(1'b0);
   endtask

   // One clock edge of the reference, using the input values held before the edge.
   task automatic model_step();
      bit press, rel, t_new, tog_new;
      press = 1; rel = 1;
      foreach (samp[i]) if (samp[i]) rel = 0; else press = 0;
      m_cyc++;
      m_cen = (m_cyc % CEN_DIV) == 0;
      t_new = (m_cyc == m_next);
      if (t_new) m_next = m_cyc + (freq_sel ? P1 : P0);
      m_ev0 = m_tick && m_ts && !dclo;
      if (!m_ts || dclo) begin
         m_ev1 = 0; m_ovr1 = 0;
      end else if (evnt_ack) begin
         m_ev1 = m_tick; m_ovr1 = 0;
      end else if (m_tick) begin
         m_ovr1 = m_ovr1 | m_ev1; m_ev1 = 1;
      end
      if (dclo) m_ts = 0;
      else if (en_we) m_ts = en_d;
      else if (m_tog) m_ts = !m_ts;
      tog_new = !dclo && press && m_armed;
      if (dclo) m_armed = 1;
      else if (press && m_armed) m_armed = 0;
      else if (rel) m_armed = 1;
      m_tog = tog_new;
      if ((m_cyc % DEB_DIV) == 0) begin
         samp.push_back(bhist[bhist.size()-2]);
         void'(samp.pop_front());
      end
      bhist.push_back(button);
      if (bhist.size() > 4) void'(bhist.pop_front());
      m_tick = t_new;
   endtask

   task automatic check_all();
      chk("cen0", cen0, m_cen);   chk("cen1", cen1, m_cen);
      chk("tick0", tick0, m_tick); chk("tick1", tick1, m_tick);
      chk("ts0", ts0, m_ts);       chk("ts1", ts1, m_ts);
      chk("evnt0", evnt0, m_ev0);  chk("ovr0", ovr0, 1'b0);
      chk("evnt1", evnt1, m_ev1);  chk("ovr1", ovr1, m_ovr1);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
         check_all();
      end
   endtask

   task automatic until_tick();
      int k = 0;
      do begin cyc(1); k++; end while (!m_tick && k < 100);
      if (!m_tick) begin
         checks++; errors++;
         $error("FAIL tick_timeout: got no tick expected tick within 100 cycles");
      end
   endtask

   initial begin
      int btn_left;
      rst_n = 1; dclo = 0; freq_sel = 0; button = 0; en_we = 0; en_d = 0; evnt_ack = 0;
      #1 rst_n = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 check_all();
      rst_n = 1;

      // free-running divider and prescaler with the timer disabled
      cyc(70);

      // press toggles on, events follow ticks; second press toggles off
      button = 1; cyc(12);
      button = 0; cyc(12);
      chk("ts_after_press", ts0, 1'b1);
      cyc(45);
      button = 1; cyc(12);
      button = 0; cyc(12);
      chk("ts_after_press2", ts0, 1'b0);

      // one-sample glitch must not toggle
      button = 1; cyc(4);
      button = 0; cyc(20);
      chk("ts_after_glitch", ts0, 1'b0);

      // rate change five cycles into a period
      until_tick();
      cyc(5);
      freq_sel = 1; cyc(40);
      freq_sel = 0; cyc(25);

      // latched events: overrun, ack, ack coincident with tick
      en_we = 1; en_d = 1; cyc(1);
      en_we = 0; en_d = 0;
      until_tick(); until_tick(); cyc(1);
      chk("ovr_set", ovr1, 1'b1);
      evnt_ack = 1; cyc(1);
      evnt_ack = 0; cyc(1);
      until_tick(); cyc(1);
      until_tick();
      evnt_ack = 1; cyc(1);
      evnt_ack = 0;
      chk("ack_tick_evnt", evnt1, 1'b1);
      chk("ack_tick_ovr", ovr1, 1'b0);
      cyc(3);

      // dclo beats a software write
      dclo = 1; en_we = 1; en_d = 1; cyc(1);
      dclo = 0; en_we = 0; en_d = 0; cyc(3);

      // dclo beats a button toggle in the same cycle
      button = 1;
      begin
         int k = 0;
         while (!m_tog && k < 40) begin cyc(1); k++; end
         if (!m_tog) begin
            checks++; errors++;
            $error("FAIL toggle_timeout: got no toggle request expected one within 40 cycles");
         end
      end
      dclo = 1; cyc(1);
      dclo = 0; button = 0; cyc(20);

      // randomized traffic
      btn_left = 0;
      for (int i = 0; i < 600; i++) begin
         if (btn_left == 0) begin
            button = 1'($urandom_range(0, 1));
            btn_left = $urandom_range(1, 16);
         end
         btn_left--;
         if ($urandom_range(0, 29) == 0) freq_sel = ~freq_sel;
         evnt_ack = ($urandom_range(0, 3) == 0);
         en_we = ($urandom_range(0, 39) == 0);
         en_d = 1'($urandom_range(0, 1));
         dclo = ($urandom_range(0, 79) == 0);
         cyc(1);
      end
      dclo = 0; en_we = 0; evnt_ack = 0; button = 0;

      // asynchronous reset in mid-period with the timer running
      en_we = 1; en_d = 1; cyc(1);
      en_we = 0; en_d = 0;
      until_tick(); cyc(7);
      #2 rst_n = 0;
      #1;
      model_reset();
      check_all();
      rst_n = 1;
      cyc(25);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
